jtcps_video_timing: RTL and testbench

Parametrised raster timing generator for the CPS video pipeline. It produces horizontal and vertical dump counters, render look-ahead line counters, blanking, sync and line-start strobes, all advancing on the pixel clock enable. It replaces the fixed-geometry timing block feeding the DMA, scroll, object and colour-mix units. Geometry is set by parameters, and an optional interlace mode adds a field toggle with an extra line on odd fields.

---
 rtl/jtcps_timing_pkg.sv | 27 ++
 rtl/jtcps_video_timing_if.sv | 41 ++++
 rtl/jtcps_wrap_cnt.sv | 42 ++++
 rtl/jtcps_video_timing.sv | 164 ++++++++++++++++
 tb/tb_jtcps_video_timing.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/jtcps_timing_pkg.sv
// Shared definitions for the CPS raster timing generator.
// Holds the default CPS geometry (pixels per line, lines per frame,
// active area and sync windows) plus typedefs for the default pixel and
// line counter widths. There are no ports; every other file in the slice
// imports this package.
package jtcps_timing_pkg;

  // Default counter widths
  localparam int CPS_HW = 9;
  localparam int CPS_VW = 9;

  // Horizontal geometry, in pixels
  localparam int CPS_HTOTAL = 512;
  localparam int CPS_HACT   = 384;
  localparam int CPS_HS_ST  = 416;
  localparam int CPS_HS_END = 452;

  // Vertical geometry, in lines (even field)
  localparam int CPS_VTOTAL = 262;
  localparam int CPS_VACT   = 224;
  localparam int CPS_VS_ST  = 236;
  localparam int CPS_VS_END = 239;

  typedef logic [CPS_HW-1:0] cps_hcnt_t;
  typedef logic [CPS_VW-1:0] cps_vcnt_t;

endpackage

// File: rtl/jtcps_video_timing_if.sv
// Raster timing bundle seen by the DMA, scroll, object and colour-mix units.
// Parameters: HW (pixel counter width), VW (line counter width).
// Signals: hdump, vdump, vrender, vrender1, start, HB, VB, HS, VS, preVB,
// field.
// Modports: master (the timing generator drives everything), slave (the
// consumers only read).
//
// Handshake semantics: there is no valid/ready pair. Every signal is
// registered and valid on every clk cycle. Counters and levels advance only
// on clk edges where the generator's pxl_cen is high. start is the one
// exception: it is a strobe that is high for exactly one clk after the edge
// on which hdump becomes 0, and consumers should qualify it with nothing
// else.
interface jtcps_video_timing_if
  import jtcps_timing_pkg::*;
#(
  parameter int HW = CPS_HW,
  parameter int VW = CPS_VW
);
  logic [HW-1:0] hdump;
  logic [VW-1:0] vdump;
  logic [VW-1:0] vrender;
  logic [VW-1:0] vrender1;
  logic          start;
  logic          HB;
  logic          VB;
  logic          HS;
  logic          VS;
  logic          preVB;
  logic          field;

  modport master (
    output hdump, vdump, vrender, vrender1, start,
    output HB, VB, HS, VS, preVB, field
  );

  modport slave (
    input hdump, vdump, vrender, vrender1, start,
    input HB, VB, HS, VS, preVB, field
  );
endinterface

// File: rtl/jtcps_wrap_cnt.sv
// Enabled modulo counter with a runtime limit.
// Parameters: W (counter width), RST_VAL (value loaded by reset).
// Ports:
//   clk, rstn  clock and asynchronous active-low reset
//   en         advance by one on this clk edge
//   limit      last value before wrapping back to 0
//   cnt        current count
//   cnt_nxt    value cnt takes on the next clk edge (for look-ahead decode)
//   tc         terminal count, high while cnt == limit
module jtcps_wrap_cnt
  import jtcps_timing_pkg::*;
#(
  parameter int             W       = CPS_HW,
  parameter logic [W-1:0]   RST_VAL = '0
)(
  input  logic         clk,
  input  logic         rstn,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic [W-1:0] cnt,
  output logic [W-1:0] cnt_nxt,
  output logic         tc
);

  assign tc = (cnt == limit);

  always_comb begin
    cnt_nxt = cnt;
    if (en) begin
      cnt_nxt = tc ? '0 : cnt + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= RST_VAL;
    end else begin
      cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/jtcps_video_timing.sv
// Parametrised CPS raster timing generator.
// Produces pixel/line dump counters, render look-ahead lines, blanking,
// sync, line-start strobe and interlace field, all advancing on pxl_cen.
// Ports:
//   clk      system clock
//   rstn     asynchronous reset, active low
//   pxl_cen  pixel clock enable
//   vid      jtcps_video_timing_if.master, carries all timing outputs; the
//            interface instance must use the same HW/VW as this module
// Optional feature: define JTCPS_TIMING_INTERLACE_EN to toggle field every
// frame, lengthen odd fields by one line and delay odd-field VS start by
// HS_ST/2 pixels. Without it field stays 0 and every frame is VTOTAL lines.
module jtcps_video_timing
  import jtcps_timing_pkg::*;
#(
  parameter int HW     = CPS_HW,
  parameter int VW     = CPS_VW,
  parameter int HTOTAL = CPS_HTOTAL,
  parameter int HACT   = CPS_HACT,
  parameter int HS_ST  = CPS_HS_ST,
  parameter int HS_END = CPS_HS_END,
  parameter int VTOTAL = CPS_VTOTAL,
  parameter int VACT   = CPS_VACT,
  parameter int VS_ST  = CPS_VS_ST,
  parameter int VS_END = CPS_VS_END
)(
  input  logic clk,
  input  logic rstn,
  input  logic pxl_cen,
  jtcps_video_timing_if.master vid
);

  localparam logic [HW-1:0] H_LAST      = HW'(HTOTAL - 1);
  localparam logic [VW-1:0] V_LAST_EVEN = VW'(VTOTAL - 1);
  localparam logic [VW-1:0] V_RST       = VW'(VACT);
`ifdef JTCPS_TIMING_INTERLACE_EN
  localparam logic [VW-1:0] V_LAST_ODD  = VW'(VTOTAL);
`endif

  localparam bit GEOM_OK = (HACT < HS_ST) && (HS_ST < HS_END) &&
                           (HS_END <= HTOTAL) &&
                           (VACT < VS_ST) && (VS_ST < VS_END) &&
                           (VS_END <= VTOTAL) &&
                           (VTOTAL + 1 < (1 << VW)) &&
                           (HTOTAL <= (1 << HW));

  geom_legal: assert property (@(posedge clk) GEOM_OK);

  logic [HW-1:0] h_cnt, h_nxt;
  logic          h_tc, h_wrap;
  logic [VW-1:0] v_cnt, v_nxt, v_last, v_last_nxt;
  logic          v_tc, v_wrap;
  logic          field_r, field_nxt;
  logic [VW-1:0] vr_nxt, vr1_nxt;
  logic          hb_nxt, hs_nxt, vb_nxt, vs_nxt, prevb_nxt;

  logic [VW-1:0] vrender_r, vrender1_r;
  logic          start_r, hb_r, vb_r, hs_r, vs_r, prevb_r;

  jtcps_wrap_cnt #(.W(HW), .RST_VAL('0)) u_hcnt (
    .clk     (clk),
    .rstn    (rstn),
    .en      (pxl_cen),
    .limit   (H_LAST),
    .cnt     (h_cnt),
    .cnt_nxt (h_nxt),
    .tc      (h_tc)
  );

  assign h_wrap = pxl_cen & h_tc;

  jtcps_wrap_cnt #(.W(VW), .RST_VAL(V_RST)) u_vcnt (
    .clk     (clk),
    .rstn    (rstn),
    .en      (h_wrap),
    .limit   (v_last),
    .cnt     (v_cnt),
    .cnt_nxt (v_nxt),
    .tc      (v_tc)
  );

  assign v_wrap = h_wrap & v_tc;

  // v_last follows the field being scanned now; v_last_nxt follows the field
  // that will be in force after this edge, so the look-ahead lines wrap at
  // the right place straight after a field change.
`ifdef JTCPS_TIMING_INTERLACE_EN
  assign field_nxt  = v_wrap ? ~field_r : field_r;
  assign v_last     = field_r   ? V_LAST_ODD : V_LAST_EVEN;
  assign v_last_nxt = field_nxt ? V_LAST_ODD : V_LAST_EVEN;
`else
  assign field_nxt  = 1'b0;
  assign v_last     = V_LAST_EVEN;
  assign v_last_nxt = V_LAST_EVEN;
`endif

  // Modular successors of the next line within the next field length.
  always_comb begin
    vr_nxt  = v_nxt + VW'(1);
    vr1_nxt = v_nxt + VW'(2);
    if (v_nxt == v_last_nxt) begin
      vr_nxt  = '0;
      vr1_nxt = VW'(1);
    end else if (vr_nxt == v_last_nxt) begin
      vr1_nxt = '0;
    end
  end

  // Levels are decoded from the next counter values so that, once
  // registered, they line up with hdump/vdump on the same cycle.
  always_comb begin
    hb_nxt    = int'(h_nxt) >= HACT;
    hs_nxt    = (int'(h_nxt) >= HS_ST) && (int'(h_nxt) < HS_END);
    vb_nxt    = int'(v_nxt) >= VACT;
    prevb_nxt = int'(vr_nxt) >= VACT;
    vs_nxt    = (int'(v_nxt) >= VS_ST) && (int'(v_nxt) < VS_END);
`ifdef JTCPS_TIMING_INTERLACE_EN
    // Odd fields: first VS line only starts at column HS_ST/2.
    if (field_nxt && (int'(v_nxt) == VS_ST) && (int'(h_nxt) < HS_ST / 2)) begin
      vs_nxt = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      start_r    <= 1'b0;
      field_r    <= 1'b0;
      vrender_r  <= VW'(VACT + 1);
      vrender1_r <= VW'(VACT + 2);
      hb_r       <= 1'b0;
      vb_r       <= 1'b1;
      hs_r       <= 1'b0;
      vs_r       <= 1'b0;
      prevb_r    <= 1'b1;
    end else begin
      // start drops on the following clk whether or not pxl_cen is high.
      start_r <= h_wrap;
      if (pxl_cen) begin
        field_r    <= field_nxt;
        vrender_r  <= vr_nxt;
        vrender1_r <= vr1_nxt;
        hb_r       <= hb_nxt;
        vb_r       <= vb_nxt;
        hs_r       <= hs_nxt;
        vs_r       <= vs_nxt;
        prevb_r    <= prevb_nxt;
      end
    end
  end

  assign vid.hdump    = h_cnt;
  assign vid.vdump    = v_cnt;
  assign vid.vrender  = vrender_r;
  assign vid.vrender1 = vrender1_r;
  assign vid.start    = start_r;
  assign vid.HB       = hb_r;
  assign vid.VB       = vb_r;
  assign vid.HS       = hs_r;
  assign vid.VS       = vs_r;
  assign vid.preVB    = prevb_r;
  assign vid.field    = field_r;

endmodule

// File: tb/tb_jtcps_video_timing.sv
// Testbench for jtcps_video_timing, using a reduced geometry so several
// whole frames fit in a short run. Follows JTCPS_TIMING_INTERLACE_EN the
// same way the design does.
module tb_jtcps_video_timing;
  import jtcps_timing_pkg::*;

  localparam int HW     = 6;
  localparam int VW     = 5;
  localparam int HTOTAL = 64;
  localparam int HACT   = 48;
  localparam int HS_ST  = 52;
  localparam int HS_END = 64;
  localparam int VTOTAL = 20;
  localparam int VACT   = 14;
  localparam int VS_ST  = 16;
  localparam int VS_END = 20;
  localparam int OW     = HW + 3 * VW + 7;

`ifdef JTCPS_TIMING_INTERLACE_EN
  localparam bit ILACE = 1'b1;
`else
  localparam bit ILACE = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk;
  logic rstn;
  logic pxl_cen;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  jtcps_video_timing_if #(.HW(HW), .VW(VW)) vid ();

  jtcps_video_timing #(
    .HW(HW), .VW(VW),
    .HTOTAL(HTOTAL), .HACT(HACT), .HS_ST(HS_ST), .HS_END(HS_END),
    .VTOTAL(VTOTAL), .VACT(VACT), .VS_ST(VS_ST), .VS_END(VS_END)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .pxl_cen (pxl_cen),
    .vid     (vid.master)
  );

  logic [OW-1:0] act_vec;
  assign act_vec = {vid.hdump, vid.vdump, vid.vrender, vid.vrender1,
                    vid.start, vid.HB, vid.VB, vid.HS, vid.VS, vid.preVB,
                    vid.field};

  // ---------------- reference model ----------------
  // Raster position as plain integers: pixel, line, field and whether the
  // last pixel step began a new line.
  int m_h;
  int m_v;
  bit m_f;
  bit m_st;

  function automatic int field_len(bit f);
    return (ILACE && f) ? VTOTAL + 1 : VTOTAL;
  endfunction

  task automatic model_reset();
    m_h  = 0;
    m_v  = VACT;
    m_f  = 1'b0;
    m_st = 1'b0;
  endtask

  task automatic model_step(bit cen);
    m_st = 1'b0;
    if (cen) begin
      m_h = m_h + 1;
      if (m_h == HTOTAL) begin
        m_h  = 0;
        m_st = 1'b1;
        m_v  = m_v + 1;
        if (m_v == field_len(m_f)) begin
          m_v = 0;
          if (ILACE) m_f = ~m_f;
        end
      end
    end
  endtask

  function automatic logic [OW-1:0] model_out();
    int flen, vr, vr1;
    bit hb, vb, hs, vs, pvb;
    flen = field_len(m_f);
    vr   = (m_v + 1) % flen;
    vr1  = (m_v + 2) % flen;
    hb   = m_h >= HACT;
    hs   = (m_h >= HS_ST) && (m_h < HS_END);
    vb   = m_v >= VACT;
    pvb  = vr >= VACT;
    vs   = (m_v >= VS_ST) && (m_v < VS_END);
    if (ILACE && m_f && m_v == VS_ST && m_h < HS_ST / 2) vs = 1'b0;
    return {HW'(m_h), VW'(m_v), VW'(vr), VW'(vr1),
            m_st, hb, vb, hs, vs, pvb, m_f};
  endfunction

  // ---------------- scoreboard ----------------
  logic [OW-1:0] exp_q[$];
  int n_vec = 0;
  int n_bad = 0;

  function automatic string fmt(logic [OW-1:0] x);
    return $sformatf("h=%0d v=%0d vr=%0d vr1=%0d st,hb,vb,hs,vs,pvb,f=%b",
                     x[OW-1 -: HW], x[OW-HW-1 -: VW], x[OW-HW-VW-1 -: VW],
                     x[OW-HW-2*VW-1 -: VW], x[6:0]);
  endfunction

  task automatic check(string name, logic [OW-1:0] got, logic [OW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got %s required %s", name, $time, fmt(got), fmt(exp));
    end
  endtask

  // Monitor: every clk the outputs are valid, so pop one expectation per
  // edge once the driver has started queuing.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) check("scoreboard", act_vec, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(bit cen);
    @(negedge clk);
    pxl_cen = cen;
    model_step(cen);
    exp_q.push_back(model_out());
  endtask

  task automatic hold_reset(int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      pxl_cen = 1'($urandom_range(0, 1));
      model_reset();
      exp_q.push_back(model_out());
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    rstn    = 1'b1;
    pxl_cen = 1'b1;
    model_step(1'b1);
    exp_q.push_back(model_out());
  endtask

  // Pull reset between clock edges and look at the outputs before any edge.
  task automatic async_reset();
    @(negedge clk);
    #1;
    rstn    = 1'b0;
    pxl_cen = 1'b0;
    #1;
    model_reset();
    check("async_reset", act_vec, model_out());
    exp_q.push_back(model_out());
    hold_reset(2);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit found;
    rstn    = 1'b0;
    pxl_cen = 1'b0;
    model_reset();

    hold_reset(3);
    release_reset();

    // Back-to-back pixel enables: more than two full frames.
    for (int i = 0; i < 3100; i++) drive(1'b1);

    // One enable every fourth clk.
    for (int i = 0; i < 5600; i++) drive((i % 4) == 3);

    // Random enables until mid-frame, then an asynchronous reset.
    for (int i = 0; i < 6000 && !(m_v == 5 && m_h == 20); i++) begin
      drive(1'($urandom_range(0, 1)));
    end
    found = (m_v == 5 && m_h == 20);
    n_vec++;
    if (!found) begin
      n_bad++;
      $display("FAIL reach_midframe got h=%0d v=%0d required h=20 v=5", m_h, m_v);
    end else begin
      async_reset();
      release_reset();
    end

    // Random enable density after reset.
    for (int i = 0; i < 3000; i++) drive($urandom_range(0, 3) != 0);
    for (int i = 0; i < 400; i++) drive(1'b1);

    @(posedge clk);
    #3;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain got %0d pending required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
